// File: rtl/dds_pkg.sv
// Shared types and defaults for the DAC serial output path.
package dds_pkg;

    localparam int DAC_DATA_W  = 16;
    localparam int DAC_CLK_DIV = 2;
    localparam int DAC_CS_IDLE = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } dac_state_t;

endpackage

// File: rtl/dac_spi_serializer_sclk_tick_gen.sv
// Half-period timer: pulses o_tick on the last of every CLK_DIV enabled cycles.
module sclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(CLK_DIV - 1));
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dac_spi_serializer.sv
// Shifts DATA_W-bit samples MSB-first to a serial DAC (sclk/sdo/cs_n),
// with a one-entry pending buffer so the next sample can queue mid-frame.
module dac_spi_serializer
    import dds_pkg::*;
#(
    parameter int DATA_W  = DAC_DATA_W,
    parameter int CLK_DIV = DAC_CLK_DIV,
    parameter int CS_IDLE = DAC_CS_IDLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              dac_sclk,
    output logic              dac_sdo,
    output logic              dac_cs_n,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = $clog2(DATA_W);
    localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

    dac_state_t        r_state;
    logic              r_pend_vld;
    logic [DATA_W-1:0] r_pend_data;
    logic [DATA_W-2:0] r_shift;
    logic [BW-1:0]     r_bit;
    logic [GW-1:0]     r_gap;
    logic              r_sclk;
    logic              r_sdo;
    logic              r_cs_n;
    logic              r_done;

    logic w_accept;
    logic w_load;
    logic w_tick;
    logic w_tick_en;
    logic w_fall;
    logic w_last_bit;
    logic w_shift;

    assign w_accept   = sample_valid && !r_pend_vld;
    assign w_load     = (r_state == IDLE) && r_pend_vld;
    assign w_tick_en  = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
    assign w_fall     = (r_state == SHIFT) && w_tick && r_sclk;
    assign w_last_bit = (r_bit == BW'(DATA_W - 1));
    assign w_shift    = w_fall && !w_last_bit;

    sclk_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_tick_en),
        .i_clr (!w_tick_en),
        .o_tick(w_tick)
    );

    // r_shift holds only the bits not yet on sdo; the MSB goes straight to sdo at load.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pend_data <= sample_in;
        end
        if (w_load) begin
            r_shift <= r_pend_data[DATA_W-2:0];
        end else if (w_shift) begin
            r_shift <= {r_shift[DATA_W-3:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pend_vld <= 1'b0;
            r_bit      <= '0;
            r_gap      <= '0;
            r_sclk     <= 1'b0;
            r_sdo      <= 1'b0;
            r_cs_n     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_pend_vld <= 1'b1;
            end else if (w_load) begin
                r_pend_vld <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state <= SETUP;
                        r_cs_n  <= 1'b0;
                        r_sdo   <= r_pend_data[DATA_W-1];
                        r_bit   <= '0;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= !r_sclk;
                        // Falling toggle: advance to the next bit, or finish after the LSB.
                        if (r_sclk) begin
                            if (w_last_bit) begin
                                r_state <= HOLD;
                            end else begin
                                r_bit <= r_bit + BW'(1);
                                r_sdo <= r_shift[DATA_W-2];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_state <= GAP;
                        r_cs_n  <= 1'b1;
                        r_done  <= 1'b1;
                        r_sdo   <= 1'b0;
                        r_gap   <= '0;
                    end
                end
                GAP: begin
                    if (r_gap == GW'(CS_IDLE - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sample_ready = !r_pend_vld;
    assign dac_sclk     = r_sclk;
    assign dac_sdo      = r_sdo;
    assign dac_cs_n     = r_cs_n;
    assign busy         = (r_state != IDLE);
    assign frame_done   = r_done;

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed + randomized bench: a DAC-side listener decodes frames from the pins
// and compares them with the samples offered on accepting edges.
module tb_dac_spi_serializer;

    localparam int DA = 16, CA = 2, IA = 2;
    localparam int DB = 8,  CB = 1, IB = 1;
    localparam int LEN_A = (2 * DA + 2) * CA;
    localparam int LEN_B = (2 * DB + 2) * CB;
    localparam int PER_A = LEN_A + IA + 1;
    localparam int PER_B = LEN_B + IB + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    vld, rdy, sclk, sdo, csn, bsy, fd;
    logic [DA-1:0] din_a;
    logic [DB-1:0] din_b;

    always #5 clk = ~clk;

    dac_spi_serializer #(.DATA_W(DA), .CLK_DIV(CA), .CS_IDLE(IA)) u_a (
        .clk(clk), .reset(rst_n), .sample_in(din_a), .sample_valid(vld[0]),
        .sample_ready(rdy[0]), .dac_sclk(sclk[0]), .dac_sdo(sdo[0]),
        .dac_cs_n(csn[0]), .busy(bsy[0]), .frame_done(fd[0]));

    dac_spi_serializer #(.DATA_W(DB), .CLK_DIV(CB), .CS_IDLE(IB)) u_b (
        .clk(clk), .reset(rst_n), .sample_in(din_b), .sample_valid(vld[1]),
        .sample_ready(rdy[1]), .dac_sclk(sclk[1]), .dac_sdo(sdo[1]),
        .dac_cs_n(csn[1]), .busy(bsy[1]), .frame_done(fd[1]));

    typedef struct {
        logic [31:0] data;
        int          nb;
        int          len;
        int          fall;
        logic        done_ok;
        int          minp;
        int          maxp;
    } frame_t;

    frame_t      fq_a[$], fq_b[$];
    logic [31:0] exp_a[$], exp_b[$];
    int          acc_a[$], acc_b[$];

    int          cyc = 0;
    int          total = 0, bad = 0;
    int          pfall[2];
    logic        m_in[2];
    logic [31:0] m_cap[2];
    int          m_nb[2], m_len[2], m_fall[2], m_last[2], m_minp[2], m_maxp[2];
    int          m_done[2], m_viol[2];
    logic [1:0]  m_psclk, m_psdo;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // DAC-side listener: samples pins on the falling clk edge, captures sdo at each sclk rise.
    initial begin
        frame_t f;
        m_in[0] = 1'b0; m_in[1] = 1'b0;
        m_done[0] = 0; m_done[1] = 0; m_viol[0] = 0; m_viol[1] = 0;
        m_psclk = '0; m_psdo = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    m_in[d] = 1'b0;
                end else begin
                    if (!m_in[d] && csn[d] === 1'b0) begin
                        m_in[d] = 1'b1; m_cap[d] = '0; m_nb[d] = 0; m_len[d] = 0;
                        m_fall[d] = cyc; m_last[d] = -1; m_minp[d] = 1 << 30; m_maxp[d] = 0;
                    end
                    if (m_in[d]) begin
                        if (csn[d] === 1'b0) begin
                            m_len[d]++;
                            if (sclk[d] && !m_psclk[d]) begin
                                m_cap[d] = {m_cap[d][30:0], sdo[d]};
                                m_nb[d]++;
                                if (m_last[d] >= 0) begin
                                    if (cyc - m_last[d] < m_minp[d]) m_minp[d] = cyc - m_last[d];
                                    if (cyc - m_last[d] > m_maxp[d]) m_maxp[d] = cyc - m_last[d];
                                end
                                m_last[d] = cyc;
                            end
                            if (sclk[d] && m_psclk[d] && sdo[d] !== m_psdo[d]) m_viol[d]++;
                        end else begin
                            f.data = m_cap[d]; f.nb = m_nb[d]; f.len = m_len[d];
                            f.fall = m_fall[d]; f.done_ok = fd[d];
                            f.minp = m_minp[d]; f.maxp = m_maxp[d];
                            if (d == 0) fq_a.push_back(f);
                            else        fq_b.push_back(f);
                            m_in[d] = 1'b0;
                        end
                    end
                    if (fd[d] === 1'b1) m_done[d]++;
                    if (csn[d] === 1'b1 && sclk[d] !== 1'b0) m_viol[d]++;
                end
                m_psclk[d] = sclk[d];
                m_psdo[d]  = sdo[d];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [31:0] v);
        int n = 0;
        @(negedge clk);
        while (rdy[d] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ready_wait%0d", d), 32'(n < 300), 32'd1);
        if (d == 0) begin
            din_a = v[DA-1:0]; exp_a.push_back(v & 32'hFFFF); acc_a.push_back(cyc + 1);
        end else begin
            din_b = v[DB-1:0]; exp_b.push_back(v & 32'hFF); acc_b.push_back(cyc + 1);
        end
        vld[d] = 1'b1;
        @(negedge clk);
        vld[d] = 1'b0;
        din_a = 16'($urandom);
        din_b = 8'($urandom);
    endtask

    task automatic check_frame(input int d, input string tag);
        frame_t      f;
        logic [31:0] ed;
        int          n = 0, ea, ef, per, len, hp, nbits;
        per   = (d == 0) ? PER_A : PER_B;
        len   = (d == 0) ? LEN_A : LEN_B;
        hp    = (d == 0) ? CA : CB;
        nbits = (d == 0) ? DA : DB;
        while (((d == 0) ? fq_a.size() : fq_b.size()) == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arrive"}, 32'(n < 500), 32'd1);
        if (n >= 500) return;
        if (d == 0) begin
            f = fq_a.pop_front(); ed = exp_a.pop_front(); ea = acc_a.pop_front();
        end else begin
            f = fq_b.pop_front(); ed = exp_b.pop_front(); ea = acc_b.pop_front();
        end
        ef = (ea + 1 > pfall[d] + per) ? ea + 1 : pfall[d] + per;
        pfall[d] = f.fall;
        chk({tag, "_data"},    f.data,          ed);
        chk({tag, "_nbits"},   32'(f.nb),       32'(nbits));
        chk({tag, "_cs_len"},  32'(f.len),      32'(len));
        chk({tag, "_fall_at"}, 32'(f.fall),     32'(ef));
        chk({tag, "_done"},    32'(f.done_ok),  32'd1);
        chk({tag, "_per_min"}, 32'(f.minp),     32'(2 * hp));
        chk({tag, "_per_max"}, 32'(f.maxp),     32'(2 * hp));
    endtask

    task automatic wait_idle(input int d, input string tag);
        int n = 0;
        while (bsy[d] !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(n < 500), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, done_before, viol;
        vld = '0; din_a = '0; din_b = '0; rst_n = 1'b0;
        pfall[0] = -1000; pfall[1] = -1000;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_ready", d), 32'(rdy[d]),  32'd1);
            chk($sformatf("rst%0d_sclk", d),  32'(sclk[d]), 32'd0);
            chk($sformatf("rst%0d_sdo", d),   32'(sdo[d]),  32'd0);
            chk($sformatf("rst%0d_cs_n", d),  32'(csn[d]),  32'd1);
            chk($sformatf("rst%0d_busy", d),  32'(bsy[d]),  32'd0);
            chk($sformatf("rst%0d_done", d),  32'(fd[d]),   32'd0);
        end
        rst_n = 1'b1;

        // single frame, defaults
        push(0, 32'hA5C3);
        check_frame(0, "t1");
        chk("t1_done_cnt", 32'(m_done[0]), 32'd1);
        wait_idle(0, "t1");

        // back-to-back with valid held high
        @(negedge clk);
        din_a = 16'hFFFF; vld[0] = 1'b1;
        chk("t2_ready_first", 32'(rdy[0]), 32'd1);
        exp_a.push_back(32'hFFFF); acc_a.push_back(cyc + 1);
        @(negedge clk);
        chk("t2_ready_drop", 32'(rdy[0]), 32'd0);
        din_a = 16'h0000;
        @(negedge clk);
        chk("t2_ready_after_load", 32'(rdy[0]), 32'd1);
        exp_a.push_back(32'h0000); acc_a.push_back(cyc + 1);
        @(negedge clk);
        chk("t2_ready_full", 32'(rdy[0]), 32'd0);
        vld[0] = 1'b0;
        check_frame(0, "t2a");
        check_frame(0, "t2b");
        chk("t2_done_cnt", 32'(m_done[0]), 32'd3);
        wait_idle(0, "t2");

        // narrow configuration
        push(1, 32'h81);
        check_frame(1, "t3");
        wait_idle(1, "t3");

        // asynchronous reset at the 7th sclk rise
        push(0, 32'h1234);
        n = 0;
        while (!(m_in[0] && m_nb[0] >= 7) && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("t4_reached_rise7", 32'(n < 500), 32'd1);
        done_before = m_done[0];
        rst_n = 1'b0;
        #1;
        chk("t4_cs_n",  32'(csn[0]),  32'd1);
        chk("t4_sclk",  32'(sclk[0]), 32'd0);
        chk("t4_sdo",   32'(sdo[0]),  32'd0);
        chk("t4_ready", 32'(rdy[0]),  32'd1);
        chk("t4_busy",  32'(bsy[0]),  32'd0);
        void'(exp_a.pop_back());
        void'(acc_a.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pfall[0] = -1000; pfall[1] = -1000;
        repeat (3) @(negedge clk);
        chk("t4_no_done", 32'(m_done[0]), 32'(done_before));
        chk("t4_no_frame", 32'(fq_a.size()), 32'd0);
        push(0, 32'h00FF);
        check_frame(0, "t4_after");
        wait_idle(0, "t4");

        // valid held, sample_in changing every cycle
        n = 0; k = 0;
        while (k < 4 && n < 2000) begin
            @(negedge clk);
            din_a = 16'($urandom);
            vld[0] = 1'b1;
            if (rdy[0] === 1'b1) begin
                exp_a.push_back({16'h0, din_a}); acc_a.push_back(cyc + 1);
                k++;
            end
            n++;
        end
        @(negedge clk);
        vld[0] = 1'b0;
        for (int i = 0; i < 4; i++) check_frame(0, $sformatf("t5_%0d", i));
        wait_idle(0, "t5");

        // random gaps on the narrow instance
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            push(1, 32'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 3; i++) check_frame(1, $sformatf("t5b_%0d", i));
        wait_idle(1, "t5b");

        // idle with no valid
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (csn[0] !== 1'b1 || sclk[0] !== 1'b0 || bsy[0] !== 1'b0 || fd[0] !== 1'b0) viol++;
        end
        chk("t6_idle_quiet", 32'(viol), 32'd0);
        chk("t6_no_frames", 32'(fq_a.size() + fq_b.size()), 32'd0);

        chk("proto_a", 32'(m_viol[0]), 32'd0);
        chk("proto_b", 32'(m_viol[1]), 32'd0);
        chk("pending_exp", 32'(exp_a.size() + exp_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
